regfile_exec_unit: RTL and testbench

Single-issue execute stage sitting directly upstream of the 8x8 register file: it accepts 16-bit instructions over a valid/ready handshake, drives the two register-file read addresses, computes an 8-bit ALU result, and writes it back through the register file's write port one cycle later. A one-entry output slot emits register values to downstream logic. Back-to-back dependent instructions are resolved by write-back forwarding, or by a one-cycle interlock when forwarding is compiled out.

---
 rtl/exec_pkg.sv | 38 +++
 rtl/exec_alu.sv | 57 +++++
 rtl/regfile_exec_unit.sv | 130 +++++++++++++
 tb/tb_regfile_exec_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the register-file execute stage.
// Holds opcode encodings, instruction field positions and datapath defaults.
// Forwarding is selected at build time with the REG_EXEC_FWD_EN macro
// (see regfile_exec_unit).
package exec_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 3;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_MOV = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_OUT = 4'hA;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Opcodes 0xB-0xF are undefined and execute as NOP.
   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_OUT;
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   op        opcode
//   a, b      operands (already forwarded where applicable)
//   imm8      immediate for LDI
//   result    ALU result, modulo 2^DW
//   carry     carry / borrow / shifted-out bit; 0 for logic ops, MOV, LDI
//   writes_rd opcode produces a register write and updates the flags
module exec_alu
   import exec_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [7:0]    imm8,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          writes_rd
);

   logic [DW:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      result    = '0;
      carry     = 1'b0;
      writes_rd = 1'b1;
      case (op)
         OP_LDI: result = DW'(imm8);
         OP_ADD: begin
            result = sum[DW-1:0];
            carry  = sum[DW];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_MOV: result = a;
         OP_SHL: begin
            result = {a[DW-2:0], 1'b0};
            carry  = a[DW-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DW-1:1]};
            carry  = a[0];
         end
         default: writes_rd = 1'b0;
      endcase
   end

endmodule

// File: rtl/regfile_exec_unit.sv
// Single-issue execute stage in front of an 8x8 register file.
// Accepts 16-bit instructions on a valid/ready handshake, reads operands
// through the register file's async read ports, and writes the ALU result
// back one cycle later through a write-back register that drives the
// register-file write port. OUT emits rs1 through a one-entry output slot.
//
// Build option: REG_EXEC_FWD_EN
//   defined   - write-back register is forwarded onto the operands
//   undefined - dependent instructions are held off one cycle instead
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_instr    instruction handshake
//   rf_raddr1/2, rf_rdata1/2      register-file read ports
//   rf_we/rf_waddr/rf_wdata       register-file write port
//   out_valid/out_ready/out_data  output slot handshake
//   flag_z, flag_c                flags from the last opcode 1-9
//   illegal                       sticky, an opcode 0xB-0xF was accepted
module regfile_exec_unit
   import exec_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_instr,
   output logic [AW-1:0] rf_raddr1,
   output logic [AW-1:0] rf_raddr2,
   input  logic [DW-1:0] rf_rdata1,
   input  logic [DW-1:0] rf_rdata2,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          flag_z,
   output logic          flag_c,
   output logic          illegal
);

   logic [3:0]    op;
   logic [AW-1:0] rd;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [7:0]    imm8;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [DW-1:0] alu_result;
   logic          alu_carry;
   logic          alu_writes;
   logic          fire;
   logic          slot_free;

   assign op   = in_instr[OP_MSB:OP_LSB];
   assign rd   = AW'(in_instr[RD_MSB:RD_LSB]);
   assign rs1  = AW'(in_instr[RS1_MSB:RS1_LSB]);
   assign rs2  = AW'(in_instr[RS2_MSB:RS2_LSB]);
   assign imm8 = in_instr[IMM_MSB:IMM_LSB];

   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   // The write-back register is the register-file write port itself.
   // wb_valid/wb_addr/wb_data are rf_we/rf_waddr/rf_wdata.
   assign slot_free = !out_valid || out_ready;

`ifdef REG_EXEC_FWD_EN
   assign opa      = (rf_we && rf_waddr == rs1) ? rf_wdata : rf_rdata1;
   assign opb      = (rf_we && rf_waddr == rs2) ? rf_wdata : rf_rdata2;
   assign in_ready = slot_free;
`else
   logic hazard;

   // LDI's imm8 overlaps the rs fields, so it must not look like a reader.
   assign hazard   = rf_we && (op != OP_NOP) && (op != OP_LDI) &&
                     ((rf_waddr == rs1) || (rf_waddr == rs2));
   assign opa      = rf_rdata1;
   assign opb      = rf_rdata2;
   assign in_ready = slot_free && !hazard;
`endif

   assign fire = in_valid && in_ready;

   exec_alu #(.DW(DW)) u_alu (
      .op        (op),
      .a         (opa),
      .b         (opb),
      .imm8      (imm8),
      .result    (alu_result),
      .carry     (alu_carry),
      .writes_rd (alu_writes)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         rf_we <= fire && alu_writes;
         if (fire && alu_writes) begin
            rf_waddr <= rd;
            rf_wdata <= alu_result;
            flag_z   <= (alu_result == '0);
            flag_c   <= alu_carry;
         end

         if (fire && is_illegal(op))
            illegal <= 1'b1;

         // A load in the drain cycle wins, keeping the slot full.
         if (fire && op == OP_OUT) begin
            out_valid <= 1'b1;
            out_data  <= opa;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_exec_unit.sv
module tb_regfile_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [2:0]  rf_raddr1;
   logic [2:0]  rf_raddr2;
   logic [7:0]  rf_rdata1;
   logic [7:0]  rf_rdata2;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        flag_z;
   logic        flag_c;
   logic        illegal;

   logic [7:0]  rf_mem [8];
   int          n_checks;
   int          n_errors;

`ifdef REG_EXEC_FWD_EN
   localparam int DEP_STALL = 0;
`else
   localparam int DEP_STALL = 1;
`endif

   regfile_exec_unit #(.DW(8), .AW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .rf_raddr1 (rf_raddr1),
      .rf_raddr2 (rf_raddr2),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file the stage sits in front of: async read, write on edge.
   initial for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;
   always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
      return {4'h1, rd, 1'b0, imm};
   endfunction

   // Present an instruction, wait (bounded) for acceptance, and return one
   // cycle after the accepting edge, i.e. while its write-back is on rf_we.
   task automatic send(input logic [15:0] ins, output int stalls);
      in_valid = 1'b1;
      in_instr = ins;
      stalls   = 0;
      @(negedge clk);
      while (!in_ready && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_instr = 16'h0000;
   endtask

   int st;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 16'h0000;
      out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_flags", {flag_z, flag_c}, 0);
      check("rst_illegal", illegal, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // LDI r1,7F; LDI r2,01; ADD r3,r1,r2 -> 80, c=0, z=0
      send(ldi(3'd1, 8'h7F), st);
      check("ldi_r1_we", rf_we, 1);
      check("ldi_r1_waddr", rf_waddr, 1);
      check("ldi_r1_wdata", rf_wdata, 8'h7F);
      send(ldi(3'd2, 8'h01), st);
      send(rr(4'h2, 3'd3, 3'd1, 3'd2), st);
      check("add_stall", st, DEP_STALL);
      check("add_waddr", rf_waddr, 3);
      check("add_wdata", rf_wdata, 8'h80);
      check("add_zc", {flag_z, flag_c}, 2'b00);

      // LDI r4,FF; ADD r4,r4,r4 back to back -> FE, c=1
      send(ldi(3'd4, 8'hFF), st);
      check("ldi_r4_stall", st, 0);
      send(rr(4'h2, 3'd4, 3'd4, 3'd4), st);
      check("dep_stall", st, DEP_STALL);
      check("dep_wdata", rf_wdata, 8'hFE);
      check("dep_zc", {flag_z, flag_c}, 2'b01);

      // LDI r5,03; SUB r6,r5,r5 -> 00 z=1; SUB r6,r0,r5 -> FD c=1
      send(ldi(3'd5, 8'h03), st);
      send(rr(4'h3, 3'd6, 3'd5, 3'd5), st);
      check("sub0_wdata", rf_wdata, 8'h00);
      check("sub0_zc", {flag_z, flag_c}, 2'b10);
      send(rr(4'h3, 3'd6, 3'd0, 3'd5), st);
      check("sub_borrow_wdata", rf_wdata, 8'hFD);
      check("sub_borrow_zc", {flag_z, flag_c}, 2'b01);

      // Other ALU ops on r4=FE, r5=03
      send(rr(4'h8, 3'd7, 3'd4, 3'd0), st);
      check("shl_wdata", rf_wdata, 8'hFC);
      check("shl_c", flag_c, 1);
      send(rr(4'h9, 3'd7, 3'd5, 3'd0), st);
      check("shr_wdata", rf_wdata, 8'h01);
      check("shr_c", flag_c, 1);
      send(rr(4'h6, 3'd7, 3'd4, 3'd5), st);
      check("xor_wdata", rf_wdata, 8'hFD);
      check("xor_c", flag_c, 0);

      // Output slot held by out_ready=0
      out_ready = 1'b0;
      send(ldi(3'd7, 8'hA5), st);
      send(rr(4'hA, 3'd0, 3'd7, 3'd0), st);
      check("out1_no_we", rf_we, 0);
      check("out1_valid", out_valid, 1);
      check("out1_data", out_data, 8'hA5);
      in_valid = 1'b1;
      in_instr = rr(4'hA, 3'd0, 3'd1, 3'd0);
      repeat (3) begin
         @(negedge clk);
         check("out_blocked_ready", in_ready, 0);
      end
      check("out_blocked_data", out_data, 8'hA5);
      out_ready = 1'b1;
      @(negedge clk);
      check("out_drain_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_instr = 16'h0000;
      check("out2_valid", out_valid, 1);
      check("out2_data", out_data, 8'h7F);
      @(posedge clk);
      #1;
      check("out_drained", out_valid, 0);

      // Illegal opcode: no write, flags kept, sticky flag
      send(rr(4'h3, 3'd6, 3'd0, 3'd5), st);
      send(16'hC000, st);
      check("illegal_no_we", rf_we, 0);
      check("illegal_flags", {flag_z, flag_c}, 2'b01);
      check("illegal_set", illegal, 1);
      send(16'h0000, st);
      send(ldi(3'd2, 8'h00), st);
      check("illegal_sticky", illegal, 1);
      check("ldi_zero_zc", {flag_z, flag_c}, 2'b10);

      // Reset with a pending OUT
      out_ready = 1'b0;
      send(rr(4'hA, 3'd0, 3'd1, 3'd0), st);
      check("pre_rst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_out_dropped", out_valid, 0);
      check("rst_clears_illegal", illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset with a pending write-back to r0 (r1=7F, r2=00)
      send(rr(4'h2, 3'd0, 3'd1, 3'd2), st);
      check("pre_rst_we", rf_we, 1);
      rst_n = 1'b0;
      #1;
      check("rst_we_dropped", rf_we, 0);
      check("rst_out_idle", out_valid, 0);
      repeat (2) @(negedge clk);
      check("rst_no_commit", rf_mem[0], 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
